// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the I/D main-memory arbiter.
//   arb_state_t : arbiter FSM states
//   ARB_PORT_I  : port ID of the instruction cache
//   ARB_PORT_D  : port ID of the data cache
//   pick_port   : chooses which cache is granted when the arbiter is idle
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam logic ARB_PORT_I = 1'b0;
  localparam logic ARB_PORT_D = 1'b1;

  // On a tie the port that was not served last wins, so neither cache can
  // starve the other under continuous contention.
  function automatic logic pick_port(input logic i_req, input logic d_req,
                                     input logic last);
    logic w_port;
    if (i_req && d_req) w_port = ~last;
    else if (d_req)     w_port = ARB_PORT_D;
    else                w_port = ARB_PORT_I;
    return w_port;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single line-wide main-memory port between the
// instruction cache and the data cache, one transaction at a time.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   in_i_read_en        I-cache line-fill request (held until ready)
//   in_i_addr           I-cache line address
//   out_i_ready         one-cycle completion pulse to the I-cache
//   out_i_read_data     fill data, 0 unless out_i_ready
//   in_d_read_en        D-cache fill request (held until ready)
//   in_d_write_en       D-cache writeback request (held until ready)
//   in_d_addr           D-cache line address
//   in_d_write_data     writeback line
//   out_d_ready         one-cycle completion pulse to the D-cache
//   out_d_read_data     fill data, 0 unless out_d_ready
//   out_mem_read_en     memory read command, held for the transaction
//   out_mem_write_en    memory write command, held for the transaction
//   out_mem_addr        latched transaction address
//   out_mem_write_data  latched writeback line
//   in_mem_ready        memory completion pulse
//   in_mem_read_data    memory read line, valid with in_mem_ready
//   out_busy            high whenever the FSM is not IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_i_read_en,
  input  logic [ADDR_WIDTH-1:0]      in_i_addr,
  output logic                       out_i_ready,
  output logic [CACHE_LINE_SIZE-1:0] out_i_read_data,
  input  logic                       in_d_read_en,
  input  logic                       in_d_write_en,
  input  logic [ADDR_WIDTH-1:0]      in_d_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_d_write_data,
  output logic                       out_d_ready,
  output logic [CACHE_LINE_SIZE-1:0] out_d_read_data,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic [ADDR_WIDTH-1:0]      out_mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
  input  logic                       in_mem_ready,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
  output logic                       out_busy
);

  arb_state_t                 r_state;
  arb_state_t                 w_next_state;
  logic                       r_port;
  logic                       r_last_grant;
  logic                       r_is_write;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [CACHE_LINE_SIZE-1:0] r_wdata;
  logic [CACHE_LINE_SIZE-1:0] r_rdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_port;
  logic w_grant_write;
  logic w_busy_mem;

  assign w_i_req       = in_i_read_en;
  assign w_d_req       = in_d_read_en | in_d_write_en;
  assign w_grant_port  = pick_port(w_i_req, w_d_req, r_last_grant);
  // Both D enables high is treated as a writeback.
  assign w_grant_write = (w_grant_port == ARB_PORT_D) && in_d_write_en;
  assign w_busy_mem    = (r_state == BUSY_I) || (r_state == BUSY_D);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_i_req || w_d_req)
          w_next_state = (w_grant_port == ARB_PORT_D) ? BUSY_D : BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (in_mem_ready) w_next_state = RESP;
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Transaction latches: loaded on grant, frozen while memory is busy so
  // that request-side changes never reach the memory port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_port       <= ARB_PORT_I;
      r_last_grant <= ARB_PORT_I;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      if (r_state == IDLE && (w_i_req || w_d_req)) begin
        r_port     <= w_grant_port;
        r_is_write <= w_grant_write;
        r_addr     <= (w_grant_port == ARB_PORT_D) ? in_d_addr : in_i_addr;
        r_wdata    <= w_grant_write ? in_d_write_data : '0;
      end
      if (w_busy_mem && in_mem_ready) begin
        r_rdata      <= in_mem_read_data;
        r_last_grant <= r_port;
      end
    end
  end

  // Outputs decode only from registered state, never from in_* directly.
  assign out_mem_read_en    = w_busy_mem && !r_is_write;
  assign out_mem_write_en   = w_busy_mem && r_is_write;
  assign out_mem_addr       = r_addr;
  assign out_mem_write_data = r_wdata;
  assign out_i_ready        = (r_state == RESP) && (r_port == ARB_PORT_I);
  assign out_d_ready        = (r_state == RESP) && (r_port == ARB_PORT_D);
  assign out_i_read_data    = out_i_ready ? r_rdata : '0;
  assign out_d_read_data    = out_d_ready ? r_rdata : '0;
  assign out_busy           = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a table of single
// transactions plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

  localparam int LW = 128;
  localparam int AW = 32;
  localparam logic P_I = 1'b0;
  localparam logic P_D = 1'b1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_i_read_en;
  logic [AW-1:0] in_i_addr;
  logic          out_i_ready;
  logic [LW-1:0] out_i_read_data;
  logic          in_d_read_en;
  logic          in_d_write_en;
  logic [AW-1:0] in_d_addr;
  logic [LW-1:0] in_d_write_data;
  logic          out_d_ready;
  logic [LW-1:0] out_d_read_data;
  logic          out_mem_read_en;
  logic          out_mem_write_en;
  logic [AW-1:0] out_mem_addr;
  logic [LW-1:0] out_mem_write_data;
  logic          in_mem_ready;
  logic [LW-1:0] in_mem_read_data;
  logic          out_busy;

  mem_arbiter #(.CACHE_LINE_SIZE(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .in_i_read_en(in_i_read_en), .in_i_addr(in_i_addr),
    .out_i_ready(out_i_ready), .out_i_read_data(out_i_read_data),
    .in_d_read_en(in_d_read_en), .in_d_write_en(in_d_write_en),
    .in_d_addr(in_d_addr), .in_d_write_data(in_d_write_data),
    .out_d_ready(out_d_ready), .out_d_read_data(out_d_read_data),
    .out_mem_read_en(out_mem_read_en), .out_mem_write_en(out_mem_write_en),
    .out_mem_addr(out_mem_addr), .out_mem_write_data(out_mem_write_data),
    .in_mem_ready(in_mem_ready), .in_mem_read_data(in_mem_read_data),
    .out_busy(out_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          i_rd;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] i_addr;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] wdata;
    int            lat;
    logic [LW-1:0] rdata;
    logic          exp_port;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " i_ready"},   LW'(out_i_ready), '0);
    chk({tag, " d_ready"},   LW'(out_d_ready), '0);
    chk({tag, " i_rdata"},   out_i_read_data, '0);
    chk({tag, " d_rdata"},   out_d_read_data, '0);
    chk({tag, " mem_rd_en"}, LW'(out_mem_read_en), '0);
    chk({tag, " mem_wr_en"}, LW'(out_mem_write_en), '0);
    chk({tag, " busy"},      LW'(out_busy), '0);
  endtask

  // Caller has already driven the requests; the next edge is the grant edge.
  task automatic txn(input string tag, input logic port, input logic wr,
                     input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                     input int lat, input logic [LW-1:0] rdata,
                     input logic chg, input logic [AW-1:0] chg_addr);
    step();
    for (int c = 0; c < lat; c++) begin
      chk({tag, " busy"},      LW'(out_busy), LW'(1'b1));
      chk({tag, " mem_rd_en"}, LW'(out_mem_read_en), LW'(!wr));
      chk({tag, " mem_wr_en"}, LW'(out_mem_write_en), LW'(wr));
      chk({tag, " mem_addr"},  LW'(out_mem_addr), LW'(addr));
      if (wr) chk({tag, " mem_wdata"}, out_mem_write_data, wdata);
      chk({tag, " early_rdy"}, LW'(out_i_ready | out_d_ready), '0);
      if (c == 0 && chg) in_d_addr = chg_addr;
      if (c == lat - 1) begin
        in_mem_ready     = 1'b1;
        in_mem_read_data = rdata;
      end
      step();
    end
    in_mem_ready     = 1'b0;
    in_mem_read_data = '0;
    chk({tag, " resp i_ready"}, LW'(out_i_ready), LW'(port == P_I));
    chk({tag, " resp d_ready"}, LW'(out_d_ready), LW'(port == P_D));
    chk({tag, " resp rd_en"},   LW'(out_mem_read_en), '0);
    chk({tag, " resp wr_en"},   LW'(out_mem_write_en), '0);
    if (port == P_I) begin
      chk({tag, " resp d_rdata"}, out_d_read_data, '0);
      if (!wr) chk({tag, " resp i_rdata"}, out_i_read_data, rdata);
    end else begin
      chk({tag, " resp i_rdata"}, out_i_read_data, '0);
      if (!wr) chk({tag, " resp d_rdata"}, out_d_read_data, rdata);
    end
    step();
    chk_quiet({tag, " post"});
  endtask

  function automatic vec_t mk(input logic i_rd, input logic d_rd, input logic d_wr,
                              input logic [AW-1:0] i_addr, input logic [AW-1:0] d_addr,
                              input logic [LW-1:0] wdata, input int lat,
                              input logic [LW-1:0] rdata, input logic exp_port,
                              input logic exp_wr, input logic [AW-1:0] exp_addr);
    vec_t v;
    v.i_rd = i_rd; v.d_rd = d_rd; v.d_wr = d_wr;
    v.i_addr = i_addr; v.d_addr = d_addr; v.wdata = wdata;
    v.lat = lat; v.rdata = rdata;
    v.exp_port = exp_port; v.exp_wr = exp_wr; v.exp_addr = exp_addr;
    return v;
  endfunction

  task automatic clear_reqs();
    in_i_read_en  = 1'b0;
    in_d_read_en  = 1'b0;
    in_d_write_en = 1'b0;
  endtask

  initial begin
    reset            = 1'b0;
    clear_reqs();
    in_i_addr        = '0;
    in_d_addr        = '0;
    in_d_write_data  = '0;
    in_mem_ready     = 1'b0;
    in_mem_read_data = '0;

    // Table, applied after the hand-written reset/tie sequence below.
    vecs[0] = mk(1, 0, 0, 32'h1000, 32'h0, '0, 5, {16{8'hAA}}, P_I, 0, 32'h1000);
    vecs[1] = mk(0, 1, 0, 32'h0, 32'h6000, '0, 3, {8{16'h1234}}, P_D, 0, 32'h6000);
    vecs[2] = mk(0, 0, 1, 32'h0, 32'h7000, {4{32'hDEADBEEF}}, 2, '0, P_D, 1, 32'h7000);
    vecs[3] = mk(0, 1, 1, 32'h0, 32'h7100, {4{32'h0BADF00D}}, 1, '0, P_D, 1, 32'h7100);
    // Last grant was D, so I wins this tie.
    vecs[4] = mk(1, 1, 0, 32'h9000, 32'h9100, '0, 2, {16{8'h3C}}, P_I, 0, 32'h9000);

    // Reset state
    repeat (3) step();
    chk_quiet("reset");
    chk("reset mem_addr",  LW'(out_mem_addr), '0);
    chk("reset mem_wdata", out_mem_write_data, '0);
    reset = 1'b1;
    step();
    chk_quiet("post-reset idle");

    // Tie right after reset: D write first, then I read.
    in_i_read_en    = 1'b1;
    in_i_addr       = 32'h2000;
    in_d_write_en   = 1'b1;
    in_d_addr       = 32'h3000;
    in_d_write_data = {16{8'h55}};
    txn("tie D", P_D, 1'b1, 32'h3000, {16{8'h55}}, 4, '0, 1'b0, '0);
    in_d_write_en = 1'b0;
    txn("tie I", P_I, 1'b0, 32'h2000, '0, 3, {16{8'hCC}}, 1'b0, '0);
    clear_reqs();
    step();

    for (int k = 0; k < 5; k++) begin
      in_i_read_en    = vecs[k].i_rd;
      in_d_read_en    = vecs[k].d_rd;
      in_d_write_en   = vecs[k].d_wr;
      in_i_addr       = vecs[k].i_addr;
      in_d_addr       = vecs[k].d_addr;
      in_d_write_data = vecs[k].wdata;
      txn($sformatf("vec%0d", k), vecs[k].exp_port, vecs[k].exp_wr, vecs[k].exp_addr,
          vecs[k].wdata, vecs[k].lat, vecs[k].rdata, 1'b0, '0);
      clear_reqs();
      step();
    end

    // Continuous contention: last grant is I, so order is D, I, D, I.
    in_i_read_en = 1'b1;
    in_i_addr    = 32'h100;
    in_d_read_en = 1'b1;
    in_d_addr    = 32'h200;
    txn("cont1 D", P_D, 1'b0, 32'h200, '0, 2, {16{8'h11}}, 1'b0, '0);
    txn("cont2 I", P_I, 1'b0, 32'h100, '0, 3, {16{8'h22}}, 1'b0, '0);
    txn("cont3 D", P_D, 1'b0, 32'h200, '0, 1, {16{8'h33}}, 1'b0, '0);
    txn("cont4 I", P_I, 1'b0, 32'h100, '0, 2, {16{8'h44}}, 1'b0, '0);
    clear_reqs();
    step();

    // Address change mid-transaction must not reach memory.
    in_d_read_en = 1'b1;
    in_d_addr    = 32'h4000;
    txn("addrchg", P_D, 1'b0, 32'h4000, '0, 4, {16{8'h77}}, 1'b1, 32'h5000);
    clear_reqs();
    step();

    // Spurious memory ready while idle.
    in_mem_ready     = 1'b1;
    in_mem_read_data = {16{8'hFF}};
    step();
    chk_quiet("spurious1");
    step();
    chk_quiet("spurious2");
    in_mem_ready     = 1'b0;
    in_mem_read_data = '0;
    step();
    chk_quiet("spurious3");

    // Reset during BUSY_D, then a late memory ready.
    in_d_read_en = 1'b1;
    in_d_addr    = 32'h8000;
    step();
    chk("rstbusy busy",  LW'(out_busy), LW'(1'b1));
    chk("rstbusy rd_en", LW'(out_mem_read_en), LW'(1'b1));
    step();
    reset = 1'b0;
    step();
    chk_quiet("rstbusy in-reset");
    chk("rstbusy mem_addr", LW'(out_mem_addr), '0);
    reset = 1'b1;
    clear_reqs();
    in_mem_ready     = 1'b1;
    in_mem_read_data = {16{8'h99}};
    step();
    in_mem_ready     = 1'b0;
    in_mem_read_data = '0;
    chk_quiet("rstbusy late-ready");
    step();
    chk_quiet("rstbusy after");
    chk("rstbusy mem_addr2", LW'(out_mem_addr), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single cache-line-wide main-memory port between the instruction cache and the data cache. Each cache issues line-fill reads or writebacks on its own request port. The arbiter grants one transaction at a time, latches its address and data, and drives the memory interface. It then returns the memory response to the granted cache as a one-cycle ready pulse. It sits between the fetch/cache stages and the memory model in `core`.

## Interface
Parameters:
- `CACHE_LINE_SIZE`, 128, line width in bits for read and write data.
- `ADDR_WIDTH`, 32, memory address width.

Ports:
- `clk`  in  1  the only clock.
- `reset`  in  1  synchronous, active-low.
- `in_i_read_en`  in  1  I-cache line-fill request, held high until ready.
- `in_i_addr`  in  ADDR_WIDTH  I-cache line address.
- `out_i_ready`  out  1  one-cycle completion pulse to the I-cache.
- `out_i_read_data`  out  CACHE_LINE_SIZE  fill data, valid only while `out_i_ready` is high.
- `in_d_read_en`, `in_d_write_en`  in  1 each  D-cache fill / writeback request, held high until ready.
- `in_d_addr`  in  ADDR_WIDTH  D-cache line address.
- `in_d_write_data`  in  CACHE_LINE_SIZE  writeback line.
- `out_d_ready`  out  1  one-cycle completion pulse to the D-cache.
- `out_d_read_data`  out  CACHE_LINE_SIZE  fill data, valid only while `out_d_ready` is high.
- `out_mem_read_en`, `out_mem_write_en`  out  1 each  memory command, held for the whole transaction.
- `out_mem_addr`  out  ADDR_WIDTH  latched address.
- `out_mem_write_data`  out  CACHE_LINE_SIZE  latched write line.
- `in_mem_ready`  in  1  memory completion pulse.
- `in_mem_read_data`  in  CACHE_LINE_SIZE  memory read line, valid with `in_mem_ready`.
- `out_busy`  out  1  high in every state other than IDLE (debug/perf).

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Sample both request ports.
  - D request only → BUSY_D. I request only → BUSY_I.
  - Both pending → grant the port that was *not* served last; `last_grant` resets to I, so D wins the first tie.
  - On grant, latch:
    - address;
    - write data (D writes only);
    - command type (write if `in_d_write_en`, else read; both D enables high counts as a write);
    - granted port ID.
- BUSY_I / BUSY_D:
  - Drive `out_mem_*` from the latches. Request inputs are ignored, so address changes do not reach memory.
  - On `in_mem_ready`, capture `in_mem_read_data` into the response register, update `last_grant`, go to RESP.
- RESP:
  - Assert the granted port's ready for exactly one cycle, with the registered data.
  - Deassert the memory enables, then go to IDLE.
  - For writebacks, ready still pulses; the data output is don't-care.
- Caches drop their request on the cycle after seeing ready. IDLE follows RESP, so a stale request is never re-granted.
- `in_mem_ready` outside the BUSY states is ignored.
- Read-data outputs are driven 0 whenever the matching ready is low.
- Reset (`reset`=0 at a clock edge) from any state:
  - go to IDLE, abandon any in-flight transaction;
  - `last_grant`=I;
  - all outputs 0: readies, memory enables, address, write data, read-data outputs, `out_busy`.

## Timing
- Request high at edge T while in IDLE → grant at T; `out_mem_*en` high from T+1.
- `in_mem_ready` at edge N → RESP during N+1: port ready high, memory enables low.
- The next request can be sampled at N+2 and granted with memory enables high from N+3.
- Latency from the request edge to the ready pulse is memory latency + 2 cycles. Per-transaction overhead is 2 idle cycles on the memory port.
- `in_mem_ready` coincident with a new request edge: the request waits until IDLE.
- No combinational path from any `in_*` to any `out_*`; all outputs are registered or decoded from the state register.

## Structure
- Shared package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, BUSY_I, BUSY_D, RESP};
  - port ID constants `ARB_PORT_I`=1'b0, `ARB_PORT_D`=1'b1;
  - a `pick_port(i_req, d_req, last)` function.
- Single flat module; no sub-module. The priority choice is one function, and everything else is the FSM plus latches.

## Test plan
- I-read only: `in_i_addr`=0x1000; memory returns 0xAA..AA after 5 cycles → `out_mem_read_en` high for 5 cycles at addr 0x1000; `out_i_ready` pulses once with 0xAA..AA; `out_d_ready` stays 0.
- Simultaneous I-read (0x2000) and D-write (0x3000, data 0x55..55) right after reset → D is granted first (write, addr 0x3000, data 0x55..55). I is granted next, with its memory enable rising 2 cycles after the D ready pulse.
- Back-to-back contention: both ports re-request continuously for 4 transactions → grant order is D, I, D, I.
- D drives `in_d_addr` from 0x4000 to 0x5000 mid-transaction → `out_mem_addr` stays 0x4000 until RESP.
- Reset asserted in BUSY_D, then `in_mem_ready` pulses after reset releases → no ready pulse on either port; FSM stays in IDLE; all outputs 0.
- Spurious `in_mem_ready` while in IDLE → no state change; no ready outputs.
